// File: rtl/sincos_pkg.sv
// Shared constants and helpers for the multi-channel quadrature NCO.
package sincos_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // ROM word: delta in the low half, value in the high half
    localparam int unsigned DELTA_LSB = 0;

    function automatic int unsigned value_lsb(input int unsigned nbo);
        return nbo;
    endfunction

    function automatic int unsigned lat(input int unsigned rom_lat);
        return 6 + rom_lat;
    endfunction

    function automatic logic q_mirror(input logic [1:0] q);
        return (q == Q1) || (q == Q3);
    endfunction

    function automatic logic q_negative(input logic [1:0] q);
        return (q == Q2) || (q == Q3);
    endfunction

endpackage

// File: rtl/sincos_interp.sv
// One lane of table interpolation: multiply, add/round, clamp/sign (3 registered stages).
module sincos_interp #(
    parameter int unsigned NBO = 18,
    parameter int unsigned NBF = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_v,
    input  logic [NBO-1:0] value,
    input  logic [NBO-1:0] delta,
    input  logic [NBF-1:0] f,
    input  logic           neg,
    output logic [NBO-1:0] y
);

    localparam int unsigned PW = NBO + NBF + 1;
    localparam logic [PW-1:0] HALF = PW'(1) << (NBF - 1);
    localparam logic [NBO:0] MAXV = {2'b00, {(NBO-1){1'b1}}};

    logic           a_v, b_v;
    logic           a_neg, b_neg;
    logic [NBO-1:0] a_val;
    logic [PW-1:0]  a_prod;
    logic [NBO:0]   b_mag;

    logic [PW-1:0]  rnd_c;
    logic [NBO:0]   sum_c;
    logic [NBO:0]   clamp_c;

    always_comb begin
        rnd_c   = (a_prod + HALF) >> NBF;
        sum_c   = (NBO+1)'(a_val) + (NBO+1)'(rnd_c);
        clamp_c = (b_mag > MAXV) ? MAXV : b_mag;
    end

    // Output holds between valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v    <= 1'b0;
            a_neg  <= 1'b0;
            a_val  <= '0;
            a_prod <= '0;
            b_v    <= 1'b0;
            b_neg  <= 1'b0;
            b_mag  <= '0;
            y      <= '0;
        end else begin
            a_v    <= in_v;
            a_neg  <= neg;
            a_val  <= value;
            a_prod <= PW'(delta) * PW'(f);
            b_v    <= a_v;
            b_neg  <= a_neg;
            b_mag  <= sum_c;
            if (b_v) begin
                y <= b_neg ? -NBO'(clamp_c) : NBO'(clamp_c);
            end
        end
    end

endmodule

// File: rtl/sincos_int_mc.sv
// Time-multiplexed multi-channel quadrature NCO with quarter-wave ROM and linear interpolation.
module sincos_int_mc
    import sincos_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned NBA     = 24,
    parameter int unsigned NBR     = 10,
    parameter int unsigned NBO     = 18,
    parameter int unsigned ROM_LAT = 2,
    localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned NBF    = NBA - 2 - NBR
) (
    input  logic             c,
    input  logic             r,
    input  logic             fw_we,
    input  logic [CW-1:0]    fw_ch,
    input  logic [NBA-1:0]   fw_d,
    input  logic             acc_clr,
    input  logic             i_valid,
    input  logic [CW-1:0]    i_ch,
    input  logic [NBA-1:0]   i_phase,
    output logic [NBR-1:0]   rom_addr_s,
    output logic [NBR-1:0]   rom_addr_c,
    input  logic [2*NBO-1:0] rom_d_s,
    input  logic [2*NBO-1:0] rom_d_c,
    output logic             o_valid,
    output logic [CW-1:0]    o_ch,
    output logic [NBO-1:0]   o_sin,
    output logic [NBO-1:0]   o_cos
);

    localparam int unsigned VAL_LSB = value_lsb(NBO);
    localparam int unsigned MW      = 1 + CW + 2*NBF + 2;

    logic [NBA-1:0] acc  [NCH];
    logic [NBA-1:0] freq [NCH];

    logic           s1_v;
    logic [CW-1:0]  s1_ch;
    logic [NBA-1:0] s1_off, s1_acc;
    logic           s2_v;
    logic [CW-1:0]  s2_ch;
    logic [NBA-1:0] s2_phase;
    logic           s3_v;
    logic [CW-1:0]  s3_ch;
    logic [NBF-1:0] s3_fs, s3_fc;
    logic           s3_ns, s3_nc;

    logic [NBA-1:0] acc_sel_c;
    logic [1:0]     q_c, qc_c;
    logic [NBA-3:0] x_c, xs_c, xc_c;

    logic [MW-1:0]  s3_meta, rd_meta;
    logic           rd_v;
    logic [CW-1:0]  rd_ch;
    logic [NBF-1:0] rd_fs, rd_fc;
    logic           rd_ns, rd_nc;

    logic           a_v, b_v;
    logic [CW-1:0]  a_ch, b_ch;

    // A coincident clear zeroes the read-back before the sample and the update use it
    assign acc_sel_c = acc_clr ? '0 : acc[i_ch];

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                freq[i] <= '0;
            end
        end else begin
            if (fw_we) begin
                freq[fw_ch] <= fw_d;
            end
            if (acc_clr) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    acc[i] <= '0;
                end
            end
            if (i_valid) begin
                acc[i_ch] <= acc_sel_c + freq[i_ch];
            end
        end
    end

    // Quadrant fold; cos is sin advanced by one quadrant
    always_comb begin
        q_c  = s2_phase[NBA-1 -: 2];
        qc_c = q_c + 2'(1);
        x_c  = s2_phase[NBA-3:0];
        xs_c = q_mirror(q_c)  ? ~x_c : x_c;
        xc_c = q_mirror(qc_c) ? ~x_c : x_c;
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            s1_v       <= 1'b0;
            s1_ch      <= '0;
            s1_off     <= '0;
            s1_acc     <= '0;
            s2_v       <= 1'b0;
            s2_ch      <= '0;
            s2_phase   <= '0;
            s3_v       <= 1'b0;
            s3_ch      <= '0;
            s3_fs      <= '0;
            s3_fc      <= '0;
            s3_ns      <= 1'b0;
            s3_nc      <= 1'b0;
            rom_addr_s <= '0;
            rom_addr_c <= '0;
        end else begin
            s1_v       <= i_valid;
            s1_ch      <= i_ch;
            s1_off     <= i_phase;
            s1_acc     <= acc_sel_c;
            s2_v       <= s1_v;
            s2_ch      <= s1_ch;
            s2_phase   <= s1_acc + s1_off;
            s3_v       <= s2_v;
            s3_ch      <= s2_ch;
            s3_fs      <= xs_c[NBF-1:0];
            s3_fc      <= xc_c[NBF-1:0];
            s3_ns      <= q_negative(q_c);
            s3_nc      <= q_negative(qc_c);
            rom_addr_s <= xs_c[NBA-3 -: NBR];
            rom_addr_c <= xc_c[NBA-3 -: NBR];
        end
    end

    assign s3_meta = {s3_v, s3_ch, s3_fs, s3_fc, s3_ns, s3_nc};

    // Side-band delay matching the external ROM read latency
    generate
        if (ROM_LAT == 0) begin : g_no_dly
            assign rd_meta = s3_meta;
        end else begin : g_dly
            logic [MW-1:0] dly [ROM_LAT];
            always_ff @(posedge c or posedge r) begin
                if (r) begin
                    for (int unsigned i = 0; i < ROM_LAT; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= s3_meta;
                    for (int unsigned i = 1; i < ROM_LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
            assign rd_meta = dly[ROM_LAT-1];
        end
    endgenerate

    assign {rd_v, rd_ch, rd_fs, rd_fc, rd_ns, rd_nc} = rd_meta;

    sincos_interp #(.NBO(NBO), .NBF(NBF)) u_sin (
        .clk   (c),
        .rst   (r),
        .in_v  (rd_v),
        .value (rom_d_s[VAL_LSB +: NBO]),
        .delta (rom_d_s[DELTA_LSB +: NBO]),
        .f     (rd_fs),
        .neg   (rd_ns),
        .y     (o_sin)
    );

    sincos_interp #(.NBO(NBO), .NBF(NBF)) u_cos (
        .clk   (c),
        .rst   (r),
        .in_v  (rd_v),
        .value (rom_d_c[VAL_LSB +: NBO]),
        .delta (rom_d_c[DELTA_LSB +: NBO]),
        .f     (rd_fc),
        .neg   (rd_nc),
        .y     (o_cos)
    );

    // Valid and channel tag ride alongside the three interpolation stages
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            a_v     <= 1'b0;
            a_ch    <= '0;
            b_v     <= 1'b0;
            b_ch    <= '0;
            o_valid <= 1'b0;
            o_ch    <= '0;
        end else begin
            a_v     <= rd_v;
            a_ch    <= rd_ch;
            b_v     <= a_v;
            b_ch    <= a_ch;
            o_valid <= b_v;
            if (b_v) begin
                o_ch <= b_ch;
            end
        end
    end

endmodule

// File: tb/tb_sincos_int_mc.sv
// Randomized and directed check of sincos_int_mc against an arithmetic NCO model.
module tb_sincos_int_mc;
    import sincos_pkg::*;

    localparam int unsigned NCH     = 4;
    localparam int unsigned NBA     = 24;
    localparam int unsigned NBR     = 10;
    localparam int unsigned NBO     = 18;
    localparam int unsigned ROM_LAT = 2;
    localparam int unsigned CW      = 2;
    localparam int unsigned LAT     = lat(ROM_LAT);
    localparam int          AMP     = 131071;
    localparam real         PI      = 3.14159265358979323846;

    logic             c, r;
    logic             fw_we, acc_clr, i_valid;
    logic [CW-1:0]    fw_ch, i_ch;
    logic [NBA-1:0]   fw_d, i_phase;
    logic [NBR-1:0]   rom_addr_s, rom_addr_c;
    logic [2*NBO-1:0] rom_d_s, rom_d_c;
    logic             o_valid;
    logic [CW-1:0]    o_ch;
    logic [NBO-1:0]   o_sin, o_cos;

    sincos_int_mc #(.NCH(NCH), .NBA(NBA), .NBR(NBR), .NBO(NBO), .ROM_LAT(ROM_LAT)) dut (
        .c(c), .r(r), .fw_we(fw_we), .fw_ch(fw_ch), .fw_d(fw_d), .acc_clr(acc_clr),
        .i_valid(i_valid), .i_ch(i_ch), .i_phase(i_phase),
        .rom_addr_s(rom_addr_s), .rom_addr_c(rom_addr_c),
        .rom_d_s(rom_d_s), .rom_d_c(rom_d_c),
        .o_valid(o_valid), .o_ch(o_ch), .o_sin(o_sin), .o_cos(o_cos)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    int unsigned cyc = 0;
    always @(posedge c) cyc <= cyc + 1;

    // Quarter-wave ROM with ROM_LAT clocks of read latency
    int val [0:1024];
    int dlt [0:1023];
    logic [2*NBO-1:0] rs [ROM_LAT];
    logic [2*NBO-1:0] rc [ROM_LAT];
    always @(posedge c) begin
        rs[0] <= {NBO'(val[rom_addr_s]), NBO'(dlt[rom_addr_s])};
        rc[0] <= {NBO'(val[rom_addr_c]), NBO'(dlt[rom_addr_c])};
        for (int i = 1; i < ROM_LAT; i++) begin
            rs[i] <= rs[i-1];
            rc[i] <= rc[i-1];
        end
    end
    assign rom_d_s = rs[ROM_LAT-1];
    assign rom_d_c = rc[ROM_LAT-1];

    typedef struct {
        int unsigned   due;
        logic [CW-1:0] ch;
        int            s;
        int            co;
        int            is;
        int            ic;
    } exp_t;

    exp_t           sb [$];
    logic [NBA-1:0] m_acc  [NCH];
    logic [NBA-1:0] m_freq [NCH];
    int             n_cmp = 0;
    int             n_bad = 0;

    function automatic int iround(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Lane value from phase: quadrant fold, table lookup, rounded linear interpolation
    function automatic int exp_lane(input logic [NBA-1:0] p, input bit cosl);
        int q, x, xm, addr, f, mag;
        q = int'(p >> 22);
        if (cosl) q = (q + 1) % 4;
        x    = int'(p & 24'h3FFFFF);
        xm   = (q % 2 == 1) ? (4194303 - x) : x;
        addr = xm / 4096;
        f    = xm % 4096;
        mag  = val[addr] + (dlt[addr] * f + 2048) / 4096;
        if (mag > AMP) mag = AMP;
        return (q >= 2) ? -mag : mag;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint ideal, input longint tol);
        n_cmp++;
        assert ((obs - ideal <= tol) && (ideal - obs <= tol)) else begin
            n_bad++;
            $error("FAIL %s observed=%0d ideal=%0d tol=%0d cyc=%0d", tag, obs, ideal, tol, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i]  = '0;
            m_freq[i] = '0;
        end
        sb.delete();
    endtask

    // One clock of stimulus; the model applies the same cycle's semantics
    task automatic step(input bit v, input int ch, input logic [NBA-1:0] ph,
                        input bit we, input int wch, input logic [NBA-1:0] wd, input bit clr);
        logic [NBA-1:0] a, p;
        exp_t e;
        @(negedge c);
        i_valid = v;  i_ch = CW'(ch);  i_phase = ph;
        fw_we = we;   fw_ch = CW'(wch); fw_d = wd;
        acc_clr = clr;
        a = clr ? '0 : m_acc[ch];
        if (v) begin
            p     = a + ph;
            e.due = cyc + LAT;
            e.ch  = CW'(ch);
            e.s   = exp_lane(p, 1'b0);
            e.co  = exp_lane(p, 1'b1);
            e.is  = iround(AMP * $sin(2.0 * PI * real'(p) / 16777216.0));
            e.ic  = iround(AMP * $cos(2.0 * PI * real'(p) / 16777216.0));
            sb.push_back(e);
        end
        if (clr) for (int i = 0; i < NCH; i++) m_acc[i] = '0;
        if (v) m_acc[ch] = a + m_freq[ch];
        if (we) m_freq[wch] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ch", o_ch, 0);
        chk("rst_o_sin", o_sin, 0);
        chk("rst_o_cos", o_cos, 0);
        chk("rst_addr_s", rom_addr_s, 0);
        chk("rst_addr_c", rom_addr_c, 0);
    endtask

    // Output monitor: o_valid must match exactly the scheduled due cycles
    always @(negedge c) begin
        bit   ev;
        exp_t e;
        ev = (sb.size() > 0) && (sb[0].due == cyc);
        chk("o_valid", o_valid, longint'(ev));
        if (ev) begin
            e = sb.pop_front();
            chk("o_ch", o_ch, e.ch);
            chk("o_sin", $signed(o_sin), e.s);
            chk("o_cos", $signed(o_cos), e.co);
            chk_tol("sin_ideal", $signed(o_sin), e.is, 2);
            chk_tol("cos_ideal", $signed(o_cos), e.ic, 2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        r = 1'b1;
        fw_we = 0; fw_ch = '0; fw_d = '0; acc_clr = 0;
        i_valid = 0; i_ch = '0; i_phase = '0;
        for (int k = 0; k <= 1024; k++) val[k] = iround(AMP * $sin(2.0 * PI * real'(k) / 4096.0));
        val[1024] = AMP;
        for (int k = 0; k < 1024; k++) dlt[k] = val[k+1] - val[k];
        model_reset();
        repeat (3) @(negedge c);
        chk_reset_outputs();
        r = 1'b0;

        // Zero phase on ch0, then the three cardinal offsets
        step(1, 0, '0, 0, 0, '0, 0);
        idle(LAT + 2);
        step(1, 0, 24'h400000, 0, 0, '0, 0);
        step(1, 0, 24'h800000, 0, 0, '0, 0);
        step(1, 0, 24'hC00000, 0, 0, '0, 0);
        idle(LAT + 2);

        // 45-degree steps on ch1 across a full turn and the wrap
        step(0, 0, '0, 1, 1, 24'h200000, 0);
        for (int i = 0; i < 9; i++) step(1, 1, '0, 0, 0, '0, 0);
        idle(LAT + 2);

        // Interleaved channels with a same-cycle frequency rewrite on ch2
        step(0, 0, '0, 1, 0, 24'h012345, 0);
        step(0, 0, '0, 1, 2, 24'h0F0000, 0);
        step(0, 0, '0, 1, 3, 24'h100000, 0);
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (i == 1 && ch == 2) step(1, 2, 24'h000100, 1, 2, 24'h3A0000, 0);
                else step(1, ch, 24'h000100, 0, 0, '0, 0);
            end
        end
        idle(LAT + 2);

        // Clear coinciding with a ch3 sample
        step(0, 0, '0, 1, 3, 24'h100000, 0);
        step(1, 3, 24'h054321, 0, 0, '0, 1);
        step(1, 3, 24'h054321, 0, 0, '0, 0);
        step(1, 0, '0, 0, 0, '0, 0);
        step(1, 1, '0, 0, 0, '0, 0);
        step(1, 2, '0, 0, 0, '0, 0);
        idle(LAT + 2);

        // Reset in the middle of a burst drops everything in flight
        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 3), 24'($urandom), 0, 0, '0, 0);
        #2;
        r = 1'b1; i_valid = 0;
        model_reset();
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge c);
        #2;
        r = 1'b0;
        idle(LAT + 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), 24'($urandom),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 24'($urandom),
                 ($urandom_range(0, 31) == 0));
        end
        idle(LAT + 3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
